// File: rtl/addsub_acc_unit.sv
// Registered W-bit add/sub unit with accumulator, sticky overflow and valid/ready handshake.
// Define ADDSUB_ACC_SAT_EN to clamp overflowing results instead of wrapping.
module addsub_acc_unit #(
   parameter int unsigned   W        = 8,
   parameter logic [W-1:0]  ACC_INIT = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   op,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         carry,
   output logic         zero,
   output logic         negative,
   output logic         overflow,
   output logic         ovf_sticky,
   output logic [W-1:0] acc
);

   localparam logic [2:0] OpAdd    = 3'd0;
   localparam logic [2:0] OpSub    = 3'd1;
   localparam logic [2:0] OpAccAdd = 3'd2;
   localparam logic [2:0] OpAccSub = 3'd3;
   localparam logic [2:0] OpLoad   = 3'd4;
   localparam logic [2:0] OpClr    = 3'd5;

   logic         out_valid_q;
   logic [W-1:0] result_q, result_d;
   logic         carry_q, carry_d;
   logic         overflow_q, overflow_d;
   logic         sticky_q, sticky_d;
   logic [W-1:0] acc_q, acc_d;

   logic         fire;
   logic         sub;
   logic         use_acc;
   logic [W-1:0] x_op;
   logic [W-1:0] b_op;
   logic [W:0]   sum_w;
   logic         add_ovf;
   logic [W-1:0] arith_res;

   assign in_ready = !out_valid_q || out_ready;
   assign fire     = in_valid && in_ready;

   always_comb begin
      sub     = (op == OpSub) || (op == OpAccSub);
      use_acc = (op == OpAccAdd) || (op == OpAccSub);
      x_op    = use_acc ? acc_q : in_a;
      b_op    = in_b ^ {W{sub}};
      // Subtraction as X + ~B + 1; carry out of bit W means "no borrow".
      sum_w   = {1'b0, x_op} + {1'b0, b_op} + {{W{1'b0}}, sub};
      add_ovf = (x_op[W-1] == b_op[W-1]) && (sum_w[W-1] != x_op[W-1]);
`ifdef ADDSUB_ACC_SAT_EN
      if (add_ovf) begin
         arith_res = x_op[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
         arith_res = sum_w[W-1:0];
      end
`else
      arith_res = sum_w[W-1:0];
`endif
   end

   always_comb begin
      result_d   = acc_q;
      carry_d    = 1'b0;
      overflow_d = 1'b0;
      acc_d      = acc_q;
      unique case (op)
         OpAdd, OpSub: begin
            result_d   = arith_res;
            carry_d    = sum_w[W];
            overflow_d = add_ovf;
         end
         OpAccAdd, OpAccSub: begin
            result_d   = arith_res;
            carry_d    = sum_w[W];
            overflow_d = add_ovf;
            acc_d      = arith_res;
         end
         OpLoad: begin
            result_d = in_a;
            acc_d    = in_a;
         end
         OpClr: begin
            result_d = ACC_INIT;
            acc_d    = ACC_INIT;
         end
         default: ;
      endcase
      sticky_d = (op == OpClr) ? 1'b0 : (sticky_q | overflow_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         sticky_q    <= 1'b0;
         acc_q       <= ACC_INIT;
      end else begin
         if (fire) begin
            out_valid_q <= 1'b1;
            result_q    <= result_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            sticky_q    <= sticky_d;
            acc_q       <= acc_d;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign result     = result_q;
   assign carry      = carry_q;
   assign zero       = (result_q == '0);
   assign negative   = result_q[W-1];
   assign overflow   = overflow_q;
   assign ovf_sticky = sticky_q;
   assign acc        = acc_q;

endmodule

// File: tb/tb_addsub_acc_unit.sv
// Self-checking bench for addsub_acc_unit (W=8): directed plan items plus random traffic
// against an integer-arithmetic reference model.
module tb_addsub_acc_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] op;
   logic [7:0] in_a, in_b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       carry, zero, negative, overflow, ovf_sticky;
   logic [7:0] acc;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: what the output register should show right now.
   bit m_valid;
   int m_result, m_carry, m_ovf, m_sticky, m_acc;

`ifdef ADDSUB_ACC_SAT_EN
   localparam bit Sat = 1'b1;
`else
   localparam bit Sat = 1'b0;
`endif

   addsub_acc_unit #(.W(8), .ACC_INIT(8'h00)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .carry      (carry),
      .zero       (zero),
      .negative   (negative),
      .overflow   (overflow),
      .ovf_sticky (ovf_sticky),
      .acc        (acc)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int to_signed8(input int v);
      return (v >= 128) ? v - 256 : v;
   endfunction

   task automatic model_reset();
      m_valid  = 1'b0;
      m_result = 0;
      m_carry  = 0;
      m_ovf    = 0;
      m_sticky = 0;
      m_acc    = 0;
   endtask

   // Apply one accepted operation to the model using plain integer arithmetic.
   task automatic model_fire(input int o, input int a, input int b);
      int x, sres, raw;
      bit is_sub;
      m_carry = 0;
      m_ovf   = 0;
      case (o)
         0, 1, 2, 3: begin
            is_sub = (o == 1) || (o == 3);
            x      = (o >= 2) ? m_acc : a;
            if (is_sub) begin
               raw     = x - b;
               m_carry = (x >= b) ? 1 : 0;
               sres    = to_signed8(x) - to_signed8(b);
            end else begin
               raw     = x + b;
               m_carry = (raw >= 256) ? 1 : 0;
               sres    = to_signed8(x) + to_signed8(b);
            end
            m_ovf    = (sres > 127 || sres < -128) ? 1 : 0;
            m_result = raw & 255;
            if (Sat && m_ovf == 1) m_result = (to_signed8(x) < 0) ? 8'h80 : 8'h7F;
            if (o >= 2) m_acc = m_result;
         end
         4: begin
            m_result = a;
            m_acc    = a;
         end
         5: begin
            m_result = 0;
            m_acc    = 0;
         end
         default: m_result = m_acc;
      endcase
      m_sticky = (o == 5) ? 0 : (m_sticky | m_ovf);
      m_valid  = 1'b1;
   endtask

   task automatic check_outputs();
      check_eq("out_valid", out_valid, m_valid);
      check_eq("acc", acc, m_acc);
      if (m_valid) begin
         check_eq("result", result, m_result);
         check_eq("carry", carry, m_carry);
         check_eq("overflow", overflow, m_ovf);
         check_eq("ovf_sticky", ovf_sticky, m_sticky);
         check_eq("zero", zero, (m_result == 0));
         check_eq("negative", negative, (m_result >= 128));
      end
   endtask

   // Called just after a falling edge: check, drive, advance one clock.
   task automatic do_cycle(input bit v, input int o, input int a, input int b, input bit rdy);
      bit exp_ready;
      check_outputs();
      in_valid  = v;
      op        = 3'(o);
      in_a      = 8'(a);
      in_b      = 8'(b);
      out_ready = rdy;
      #1;
      exp_ready = !m_valid || rdy;
      check_eq("in_ready", in_ready, exp_ready);
      if (v && exp_ready) model_fire(o, a, b);
      else if (rdy) m_valid = 1'b0;
      @(negedge clk);
   endtask

   function automatic int pick_operand();
      int sel = $urandom_range(0, 7);
      case (sel)
         0: return 8'h7F;
         1: return 8'h80;
         2: return 8'h00;
         3: return 8'hFF;
         default: return $urandom_range(0, 255);
      endcase
   endfunction

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      op        = 3'd0;
      in_a      = 8'h00;
      in_b      = 8'h00;
      out_ready = 1'b0;
      model_reset();
      #2;
      check_outputs();
      check_eq("rst_zero", zero, 1'b1);
      check_eq("rst_result", result, 8'h00);
      @(negedge clk);
      rst = 1'b0;

      // Signed overflow on ADD
      do_cycle(1, 0, 8'h7F, 8'h01, 1);
      check_eq("add7f_result", result, Sat ? 8'h7F : 8'h80);
      check_eq("add7f_ovf", overflow, 1'b1);
      check_eq("add7f_carry", carry, 1'b0);
      check_eq("add7f_sticky", ovf_sticky, 1'b1);
      do_cycle(1, 1, 8'h05, 8'h05, 1);
      check_eq("sub_eq_zero", zero, 1'b1);
      check_eq("sub_eq_carry", carry, 1'b1);
      do_cycle(1, 1, 8'h00, 8'h01, 1);
      check_eq("sub_borrow_res", result, 8'hFF);
      check_eq("sub_borrow_carry", carry, 1'b0);
      // Accumulator chain then clear
      do_cycle(1, 4, 8'h10, 8'h00, 1);
      do_cycle(1, 2, 8'h00, 8'h20, 1);
      check_eq("acc_add_res", result, 8'h30);
      do_cycle(1, 3, 8'h00, 8'h05, 1);
      check_eq("acc_sub_acc", acc, 8'h2B);
      do_cycle(1, 5, 8'h00, 8'h00, 1);
      check_eq("clr_acc", acc, 8'h00);
      check_eq("clr_sticky", ovf_sticky, 1'b0);
      // ACC_SUB overflow from the most negative value
      do_cycle(1, 4, 8'h80, 8'h00, 1);
      do_cycle(1, 3, 8'h00, 8'h01, 1);
      check_eq("accsub80_res", result, Sat ? 8'h80 : 8'h7F);
      check_eq("accsub80_ovf", overflow, 1'b1);
      // Backpressure: held output, stalled input, then drain at full rate
      do_cycle(1, 6, 8'h00, 8'h00, 0);
      for (int i = 0; i < 3; i++) do_cycle(1, 2, 8'h00, 8'h01, 0);
      for (int i = 0; i < 4; i++) do_cycle(1, 2, 8'h00, 8'h01, 1);
      do_cycle(0, 0, 8'h00, 8'h00, 1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7), pick_operand(),
                  pick_operand(), $urandom_range(0, 9) < 7);
      end

      // Reset asserted mid-stream while a result is held
      do_cycle(1, 4, 8'h55, 8'h00, 1);
      do_cycle(1, 0, 8'h7F, 8'h7F, 0);
      check_eq("pre_rst_valid", out_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      check_eq("midrst_zero", zero, 1'b1);
      check_eq("midrst_sticky", ovf_sticky, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         do_cycle($urandom_range(0, 1), $urandom_range(0, 7), pick_operand(),
                  pick_operand(), $urandom_range(0, 1));
      end
      check_outputs();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/addsub_acc_unit.md
Name: addsub_acc_unit

Overview:
- Parametrised, registered successor to the 4-bit combinational adder/subtractor: W-bit two's-complement add/sub with an internal accumulator, sticky overflow and a valid/ready handshake on both sides.
- Sits between the ALU operand mux and the result writeback/display logic.
- One operation accepted per cycle.
- Result and flags are registered, so latency is 1 cycle.

Parameters:
- W, 8, operand/result/accumulator width in bits (W >= 2).
- ACC_INIT, 0, value the accumulator takes at reset and on CLR.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept the request this cycle.
- op  in  3  0 ADD, 1 SUB, 2 ACC_ADD, 3 ACC_SUB, 4 LOAD, 5 CLR, 6-7 reserved.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  W  registered result.
- carry  out  1  carry out of the W-bit adder.
- zero  out  1  result == 0.
- negative  out  1  result[W-1].
- overflow  out  1  signed overflow of this operation.
- ovf_sticky  out  1  OR of overflow over all ops since reset/CLR.
- acc  out  W  current accumulator value.

Behaviour:
- Reset (async, immediate): out_valid=0, result=0, carry=0, zero=1, negative=0, overflow=0, ovf_sticky=0, acc=ACC_INIT. Reset mid-operation discards any held result; no partial update survives.
- Handshake: in_ready = !out_valid || out_ready (single output register, no skid). An op fires when in_valid && in_ready. out_valid rises the cycle after a fire. out_valid drops after out_ready when no new fire occurs in that cycle. Back-to-back fire plus drain in the same cycle is allowed and gives full throughput. While out_valid && !out_ready, result and flags hold stable.
- Arithmetic:
  - X = in_a for ADD/SUB; X = acc for ACC_ADD/ACC_SUB.
  - sub = op is SUB or ACC_SUB. B' = in_b XOR {W{sub}}.
  - {carry, sum} = X + B' + sub, computed (W+1) bits wide.
  - For SUB, carry=1 means no borrow.
  - overflow = (X[W-1] == B'[W-1]) && (sum[W-1] != X[W-1]).
  - result = sum.
- Accumulator: ACC_ADD/ACC_SUB write acc <= result at the fire edge. ADD/SUB leave acc unchanged.
- LOAD: acc <= in_a, result = in_a, carry=0, overflow=0.
- CLR: acc <= ACC_INIT, result = ACC_INIT, carry=0, overflow=0, ovf_sticky <= 0.
- Reserved op: treated as a no-op that still produces a response. result = acc, carry=0, overflow=0, acc unchanged.
- Flags: zero and negative are always derived from the registered result. ovf_sticky <= ovf_sticky | overflow on every fire except CLR.
- Wrap-around: without the optional feature, results wrap modulo 2^W, e.g. 0x7F+0x01 gives 0x80 with overflow=1.
- Simultaneous events: an accumulator op that fires in the cycle the previous acc result drains uses the already-updated acc. There is no hazard, because acc is written at the fire edge.

Optional Feature:
- Macro ADDSUB_ACC_SAT_EN.
- Defined: saturating arithmetic. On overflow, result (and acc for ACC ops) is clamped to 2^(W-1)-1 when X is non-negative, or to -2^(W-1) when X is negative. overflow and ovf_sticky still assert. carry reports the raw adder carry. zero and negative reflect the clamped result.
- Undefined: wrap-around as described above, with no clamp logic in the netlist.

Test Plan (W=8, ACC_INIT=0):
- Reset asserted mid-stream while out_valid=1 -> out_valid=0, acc=0x00, zero=1, ovf_sticky=0 immediately, without waiting for a clock edge.
- ADD 0x7F+0x01 -> next cycle result=0x80, overflow=1, negative=1, carry=0, ovf_sticky=1. With ADDSUB_ACC_SAT_EN: result=0x7F.
- SUB 0x05-0x05 -> result=0x00, zero=1, carry=1, overflow=0. SUB 0x00-0x01 -> result=0xFF, carry=0, negative=1.
- LOAD 0x10, then ACC_ADD b=0x20, then ACC_SUB b=0x05 -> results 0x10, 0x30, 0x2B and acc=0x2B. Then CLR -> acc=0x00 and ovf_sticky cleared.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result held stable, acc not updated. Releasing out_ready -> ops proceed one per cycle with no loss or duplication.
- ACC_SUB 0x80-0x01 starting from acc=0x80 -> result=0x7F, overflow=1. With ADDSUB_ACC_SAT_EN: result=0x80.
